// File: rtl/matrix_mult_core.sv
// matrix_mult_core: loads A and B (N x N, W-bit unsigned) one element per
// request/response handshake, then computes C = A*B with one MAC per cycle.
module matrix_mult_core #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             data_request,
  input  logic [W-1:0]     din,
  input  logic             din_valid,
  output logic [2*W+1:0]   dout,
  output logic             dout_valid,
  output logic [1:0]       dout_row,
  output logic [1:0]       dout_col,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NE = 2 * N * N;
  localparam int unsigned EW = $clog2(NE);
  localparam int unsigned DW = 2 * W + 2;

  localparam logic [EW-1:0] E_LAST = EW'(NE - 1);
  localparam logic [EW-1:0] N_E    = EW'(N);
  localparam logic [EW-1:0] NN_E   = EW'(N * N);
  localparam logic [1:0]    I_LAST = 2'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    COMPUTE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   e_q, e_d;
  logic [1:0]      i_q, i_d;
  logic [1:0]      j_q, j_d;
  logic [1:0]      k_q, k_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic            last_q, last_d;

  logic            data_request_q, data_request_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic [1:0]      dout_row_q, dout_row_d;
  logic [1:0]      dout_col_q, dout_col_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W-1:0]    mem_q [2**EW];

  logic [EW-1:0]   a_idx;
  logic [EW-1:0]   b_idx;
  logic [2*W-1:0]  prod;
  logic [DW-1:0]   sum;

  // Element store: written only while waiting for a response; never reset.
  always_ff @(posedge clk) begin
    if (state_q == WAIT && din_valid) begin
      mem_q[e_q] <= din;
    end
  end

  // MAC datapath: A[i][k] * B[k][j] added to the running sum.
  always_comb begin
    a_idx = EW'(i_q) * N_E + EW'(k_q);
    b_idx = NN_E + EW'(k_q) * N_E + EW'(j_q);
    prod  = {{W{1'b0}}, mem_q[a_idx]} * {{W{1'b0}}, mem_q[b_idx]};
    sum   = acc_q + DW'(prod);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    e_d          = e_q;
    i_d          = i_q;
    j_d          = j_q;
    k_d          = k_q;
    acc_d        = acc_q;
    last_d       = last_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dout_row_d   = dout_row_q;
    dout_col_d   = dout_col_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          e_d     = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          last_d  = 1'b0;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (din_valid) begin
          if (e_q == E_LAST) begin
            state_d = COMPUTE;
          end else begin
            e_d     = e_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      COMPUTE: begin
        // One drain cycle after the final MAC lets the last result
        // appear before DONE.
        if (last_q) begin
          state_d = DONE;
          last_d  = 1'b0;
        end else if (k_q == I_LAST) begin
          acc_d        = '0;
          dout_d       = sum;
          dout_valid_d = 1'b1;
          dout_row_d   = i_q;
          dout_col_d   = j_q;
          k_d          = '0;
          if (j_q == I_LAST) begin
            j_d = '0;
            if (i_q == I_LAST) begin
              last_d = 1'b1;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    data_request_d = (state_d == REQ);
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
  end

  // Control state, counters, accumulator and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      e_q            <= '0;
      i_q            <= '0;
      j_q            <= '0;
      k_q            <= '0;
      acc_q          <= '0;
      last_q         <= 1'b0;
      data_request_q <= 1'b0;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      dout_row_q     <= '0;
      dout_col_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      e_q            <= e_d;
      i_q            <= i_d;
      j_q            <= j_d;
      k_q            <= k_d;
      acc_q          <= acc_d;
      last_q         <= last_d;
      data_request_q <= data_request_d;
      dout_q         <= dout_d;
      dout_valid_q   <= dout_valid_d;
      dout_row_q     <= dout_row_d;
      dout_col_q     <= dout_col_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign data_request = data_request_q;
  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign dout_row     = dout_row_q;
  assign dout_col     = dout_col_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_matrix_mult_core.sv
module tb_matrix_mult_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        data_request;
  logic [7:0]  din;
  logic        din_valid;
  logic [17:0] dout;
  logic        dout_valid;
  logic [1:0]  dout_row;
  logic [1:0]  dout_col;
  logic        busy;
  logic        done;

  int ntests = 0;
  int nfail  = 0;

  int unsigned gen_data [18];
  int unsigned gen_idx       = 0;
  int unsigned job_base      = 0;
  int unsigned req_cnt       = 0;
  int unsigned gen_lat       = 1;
  bit          gen_inj       = 1'b0;
  int unsigned idle_inj_n    = 0;
  int unsigned idle_inj_done = 0;

  matrix_mult_core #(.W(8), .N(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .data_request (data_request),
    .din          (din),
    .din_valid    (din_valid),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_row     (dout_row),
    .dout_col     (dout_col),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Upstream data generator: answers each request after gen_lat cycles,
  // optionally injecting junk din_valid in the request cycle or when idle.
  initial begin
    din       = '0;
    din_valid = 1'b0;
    forever begin
      @(negedge clk);
      din_valid = 1'b0;
      if (idle_inj_n != idle_inj_done) begin
        idle_inj_done++;
        din       = 8'($urandom_range(1, 255));
        din_valid = 1'b1;
      end else if (data_request === 1'b1 && rst_n === 1'b1) begin
        req_cnt++;
        if (gen_inj) begin
          din       = 8'($urandom_range(1, 255));
          din_valid = 1'b1;
        end
        repeat (gen_lat) begin
          @(negedge clk);
          din_valid = 1'b0;
        end
        if (gen_idx - job_base < 18) din = 8'(gen_data[gen_idx - job_base]);
        else                         din = '0;
        din_valid = 1'b1;
        gen_idx++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_request"}, data_request, 0);
    chk({tag, "_dout"},         dout, 0);
    chk({tag, "_dout_valid"},   dout_valid, 0);
    chk({tag, "_dout_row"},     dout_row, 0);
    chk({tag, "_dout_col"},     dout_col, 0);
    chk({tag, "_busy"},         busy, 0);
    chk({tag, "_done"},         done, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 18; i++) gen_data[i] = $urandom_range(0, 255);
  endtask

  task automatic run_job(input int unsigned lat, input bit inj, input bit busy_starts);
    int unsigned exp_c [9];
    int unsigned nres, last_c, req_base, extra;
    bit          got_done, sent2;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        exp_c[i*3+j] = 0;
        for (int k = 0; k < 3; k++) exp_c[i*3+j] += gen_data[i*3+k] * gen_data[9+k*3+j];
      end
    end
    gen_lat  = lat;
    gen_inj  = inj;
    job_base = gen_idx;
    req_base = req_cnt;
    nres     = 0;
    last_c   = 0;
    got_done = 1'b0;
    sent2    = 1'b0;
    chk("busy_before_start", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("request_after_start", data_request, 1);
    for (int unsigned c = 1; c < 5000 && !got_done; c++) begin
      if (dout_valid === 1'b1) begin
        if (nres < 9) begin
          chk("dout", dout, exp_c[nres]);
          chk("dout_row", dout_row, nres / 3);
          chk("dout_col", dout_col, nres % 3);
        end
        if (nres > 0) chk("dout_spacing", c - last_c, 3);
        last_c = c;
        nres++;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        chk("done_after_last_dout", c - last_c, 1);
        chk("busy_at_done", busy, 1);
      end
      start = 1'b0;
      if (busy_starts && (c == 3 || (nres == 1 && !sent2))) begin
        start = 1'b1;
        if (nres == 1) sent2 = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("result_count", nres, 9);
    chk("request_count", req_cnt - req_base, 18);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("dout_hold", dout, exp_c[8]);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (dout_valid !== 1'b0 || done !== 1'b0 || data_request !== 1'b0) extra++;
    end
    chk("quiet_after_job", extra, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identity A, B = 1..9
    for (int i = 0; i < 9; i++) gen_data[i] = (i % 4 == 0) ? 1 : 0;
    for (int i = 0; i < 9; i++) gen_data[9+i] = i + 1;
    run_job(1, 1'b0, 1'b0);

    // All-maximum elements
    for (int i = 0; i < 18; i++) gen_data[i] = 255;
    run_job(2, 1'b0, 1'b0);

    // Random data, 3-cycle latency, junk din_valid in IDLE and REQ,
    // extra start pulses during WAIT and COMPUTE
    fill_random();
    idle_inj_n += 2;
    repeat (4) @(negedge clk);
    run_job(3, 1'b1, 1'b1);

    // Reset after the 7th element of a load
    fill_random();
    gen_lat  = 1;
    gen_inj  = 1'b0;
    job_base = gen_idx;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000 && (gen_idx - job_base) != 7; c++) @(posedge clk);
    chk("reached_7th_element", gen_idx - job_base, 7);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midload_reset");
    #98;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_no_request", data_request, 0);
    chk("post_reset_busy", busy, 0);
    fill_random();
    run_job(1, 1'b0, 1'b0);

    // Further random jobs with random latency
    for (int n = 0; n < 3; n++) begin
      fill_random();
      run_job($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
